// File: rtl/execute_stage.sv
// Execute stage of an ARM-style pipeline: one registered ALU result per cycle,
// NZCV flag register, valid/ready handshake towards writeback and a flush input.
// Optional feature: define EXECUTE_COND_EXEC_EN to evaluate the cond field.
// Without that macro every instruction is treated as condition-passed.
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic [3:0]       rd_in,
  input  logic [WIDTH-1:0] rn_val,
  input  logic [WIDTH-1:0] op2,
  input  logic             shift_carry,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_out,
  output logic             wb_en,
  output logic [3:0]       flags
);

  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } opcode_e;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  logic             accept;
  logic             cond_pass;
  logic             is_test;
  logic             arith;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_new, v_new;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // TST, TEQ, CMP and CMN occupy opcodes 10xx and never write the register file.
  assign is_test  = (opcode[3:2] == 2'b10);

`ifdef EXECUTE_COND_EXEC_EN
  // Condition check against the flag register as it stands in the acceptance cycle.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign cond_pass   = 1'b1;
`endif

  // ALU: one shared adder for all arithmetic ops, subtraction as x + ~y + cin.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    arith   = 1'b0;
    add_x   = rn_val;
    add_y   = op2;
    add_cin = 1'b0;
    alu_res = '0;
    case (opcode_e'(opcode))
      OP_SUB, OP_CMP: begin arith = 1'b1; add_y = ~op2; add_cin = 1'b1;   end
      OP_RSB:         begin arith = 1'b1; add_x = op2; add_y = ~rn_val; add_cin = 1'b1; end
      OP_ADD, OP_CMN: begin arith = 1'b1;                                 end
      OP_ADC:         begin arith = 1'b1; add_cin = flag_c;               end
      OP_SBC:         begin arith = 1'b1; add_y = ~op2; add_cin = flag_c; end
      OP_RSC:         begin arith = 1'b1; add_x = op2; add_y = ~rn_val; add_cin = flag_c; end
      default:        arith = 1'b0;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    case (opcode_e'(opcode))
      OP_AND, OP_TST: alu_res = rn_val & op2;
      OP_EOR, OP_TEQ: alu_res = rn_val ^ op2;
      OP_ORR:         alu_res = rn_val | op2;
      OP_MOV:         alu_res = op2;
      OP_BIC:         alu_res = rn_val & ~op2;
      OP_MVN:         alu_res = ~op2;
      default:        alu_res = add_sum[WIDTH-1:0];
    endcase
    // Logical ops take C from the shifter and keep V; arithmetic uses the adder.
    c_new = arith ? add_sum[WIDTH] : shift_carry;
    v_new = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != add_x[WIDTH-1]))
                  : flag_v;
  end

  // NZCV register: written on acceptance of a passing flag-setting or test op.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      flags <= 4'b0000;
    end else if (accept && cond_pass && (set_flags || is_test)) begin
      flags <= {alu_res[WIDTH-1], (alu_res == '0), c_new, v_new};
    end
  end

  // Output register: flush kills, acceptance loads, consumption empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      result    <= '0;
      rd_out    <= 4'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      wb_en     <= cond_pass && !is_test;
      result    <= alu_res;
      rd_out    <= rd_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
    end
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  shifter stage presents an instruction.
REQ-005 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port opcode  input  4  ARM data-processing opcode.
REQ-007 SHALL have port cond  input  4  ARM condition field.
REQ-008 SHALL have port set_flags  input  1  S bit.
REQ-009 SHALL have port rd_in  input  4  destination register index.
REQ-010 SHALL have port rn_val  input  WIDTH  first operand.
REQ-011 SHALL have port op2  input  WIDTH  shifted second operand from the shifter stage.
REQ-012 SHALL have port shift_carry  input  1  shifter carry-out.
REQ-013 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-014 SHALL have port out_valid  output  1  result register holds an instruction.
REQ-015 SHALL have port out_ready  input  1  writeback consumes the result this cycle.
REQ-016 SHALL have port result  output  WIDTH  registered ALU result.
REQ-017 SHALL have port rd_out  output  4  registered destination index.
REQ-018 SHALL have port wb_en  output  1  register-file write enable for the held result.
REQ-019 SHALL have port flags  output  4  current NZCV register, bit 3 = N.

Function
REQ-020 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-021 SHALL accept an instruction when in_valid && in_ready && !flush; result appears on the next rising edge (1-cycle latency).
REQ-022 SHALL hold result, rd_out, wb_en and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid after a cycle with out_ready high and no acceptance; back-to-back acceptance with out_ready high SHALL sustain one instruction per cycle.
REQ-024 SHALL implement AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN for opcodes 0000-1111, in that order.
REQ-025 SHALL compute arithmetic modulo 2^WIDTH; C for subtraction = NOT borrow; ADC/SBC/RSC SHALL use the C bit of the flags register.
REQ-026 SHALL, for logical ops, set C = shift_carry and leave V unchanged; arithmetic ops set V = signed overflow.
REQ-027 SHALL set N = result MSB, Z = (result == 0) for every flag-updating op.
REQ-028 SHALL update flags on the acceptance edge only when set_flags = 1 and condition passes; TST/TEQ/CMP/CMN SHALL update flags regardless of set_flags.
REQ-029 SHALL set wb_en = 0 for TST/TEQ/CMP/CMN and for condition-failed instructions; these still occupy the output register with out_valid = 1.
REQ-030 SHALL evaluate cond against the flags register value present in the acceptance cycle, so an instruction accepted immediately after a flag-setting one sees the updated flags.
REQ-031 SHALL treat cond 1110 as always and 1111 as never.
REQ-032 SHALL, on flush, clear out_valid and wb_en at the next edge, discard any simultaneous input, and leave flags unchanged; flush SHALL override out_ready and in_valid.

Reset
REQ-033 SHALL, while reset_n = 0, force out_valid = 0, wb_en = 0, result = 0, rd_out = 0 and flags = 0000 immediately, independent of clk.
REQ-034 SHALL drop any held or in-flight instruction when reset asserts mid-operation; first acceptance is possible on the first rising edge after reset_n returns high.

Configuration
REQ-035 SHALL, with macro EXECUTE_COND_EXEC_EN defined, evaluate all sixteen condition codes per REQ-030/031.
REQ-036 SHALL, without EXECUTE_COND_EXEC_EN, ignore cond and treat every instruction as condition-passed; all other behaviour is unchanged.

Verification
REQ-037 SHALL cover ADD rn_val=0x7FFFFFFF, op2=1, S=1 -> result 0x80000000, flags 1001, wb_en 1 one cycle later.
REQ-038 SHALL cover CMP rn_val=5, op2=5 -> flags 0110, wb_en 0, out_valid 1.
REQ-039 SHALL cover CMP 5,5 followed next cycle by MOV cond=0000 (EQ) op2=0xAB -> result 0xAB, wb_en 1; repeat with cond=0001 (NE) -> wb_en 0.
REQ-040 SHALL cover out_ready held low 3 cycles with in_valid high -> in_ready 0, outputs stable, no second instruction lost after out_ready returns high.
REQ-041 SHALL cover flush asserted together with in_valid and a held result -> out_valid 0 next cycle, flags unchanged.
REQ-042 SHALL cover reset_n pulled low mid-stall -> out_valid, wb_en, result and flags read 0 before the next clock edge.
